vproc_div_respack: RTL and testbench

Result packer directly downstream of the vector divide unit. Consumes the divider's DIV_OP_W-wide result beats, each with a byte mask and destination register, through a valid/ready handshake. Assembles consecutive beats into a full VREG_W-wide vector register write with per-byte write enables. Issues that write to the register-file write port through a second valid/ready handshake.

---
 rtl/vproc_pkg.sv | 27 ++
 rtl/vproc_div_respack_acc.sv | 99 +++++++++
 rtl/vproc_div_respack.sv | 83 ++++++++
 tb/tb_vproc_div_respack.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vproc_pkg.sv
// Shared vector-processor types and helpers: divider result-group sizing and
// the register-file write request carried by the divide result packer.
package vproc_pkg;

    localparam int unsigned DIV_WR_ADDR_W = 5;
    localparam int unsigned DIV_WR_DATA_W = 128;
    localparam int unsigned DIV_WR_BE_W   = DIV_WR_DATA_W / 8;

    typedef struct packed {
        logic [DIV_WR_ADDR_W-1:0] addr;
        logic [DIV_WR_DATA_W-1:0] data;
        logic [DIV_WR_BE_W-1:0]   be;
    } div_wr_req_t;

    // Number of result beats that make up one vector register.
    function automatic int unsigned div_beats(input int unsigned op_w, input int unsigned vreg_w);
        return vreg_w / op_w;
    endfunction

    // Slot counter width; at least one bit even for single-beat groups.
    function automatic int unsigned div_cnt_w(input int unsigned op_w, input int unsigned vreg_w);
        int unsigned n;
        n = vreg_w / op_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vproc_div_respack_acc.sv
// Slot counter, byte-enable/data accumulator and merge of the incoming beat.
// Consistency checking is built only with VPROC_DIV_RESPACK_ERRCHK_EN.
module vproc_div_respack_acc
    import vproc_pkg::*;
#(
    parameter int unsigned DIV_OP_W       = 64,
    parameter int unsigned VREG_W         = 128,
    parameter int unsigned VADDR_W        = 5,
    parameter logic        DONT_CARE_ZERO = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    async_rst_ni,
    input  logic                    sync_rst_ni,
    input  logic                    beat_fire,
    input  logic [DIV_OP_W-1:0]     beat_res,
    input  logic [DIV_OP_W/8-1:0]   beat_mask,
    input  logic [VADDR_W-1:0]      beat_vd,
    input  logic                    beat_last,
    output logic                    complete_c,
    output logic [VREG_W-1:0]       merged_data_c,
    output logic [VREG_W/8-1:0]     merged_be_c,
    output logic [VADDR_W-1:0]      merged_vd_c,
    output logic                    err
);

    localparam int unsigned N      = div_beats(DIV_OP_W, VREG_W);
    localparam int unsigned CNT_W  = div_cnt_w(DIV_OP_W, VREG_W);
    localparam int unsigned MASK_W = DIV_OP_W / 8;

    logic [CNT_W-1:0]    cnt;
    logic [VREG_W-1:0]   acc_data;
    logic [VREG_W/8-1:0] acc_be;
    logic [VADDR_W-1:0]  acc_vd;

    assign complete_c  = (cnt == CNT_W'(N - 1)) | beat_last;
    assign merged_vd_c = (cnt == '0) ? beat_vd : acc_vd;

    // Current beat lands in slot cnt; slots above it are not yet written.
    always_comb begin
        merged_data_c = acc_data;
        merged_be_c   = acc_be;
        for (int unsigned i = 0; i < N; i++) begin
            if (CNT_W'(i) == cnt) begin
                merged_data_c[i*DIV_OP_W +: DIV_OP_W] = beat_res;
                merged_be_c[i*MASK_W +: MASK_W]       = beat_mask;
            end else if (CNT_W'(i) > cnt) begin
                merged_data_c[i*DIV_OP_W +: DIV_OP_W] = {DIV_OP_W{DONT_CARE_ZERO ? 1'b0 : 1'bx}};
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt    <= '0;
            acc_be <= '0;
        end else if (!sync_rst_ni) begin
            cnt    <= '0;
            acc_be <= '0;
        end else if (beat_fire) begin
            if (complete_c) begin
                cnt    <= '0;
                acc_be <= '0;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                acc_be <= merged_be_c;
            end
        end
    end

    // Data and address need no reset: validity is tracked by acc_be and cnt.
    always_ff @(posedge clk_i) begin
        if (beat_fire) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (CNT_W'(i) == cnt) begin
                    acc_data[i*DIV_OP_W +: DIV_OP_W] <= beat_res;
                end
            end
            if (cnt == '0) begin
                acc_vd <= beat_vd;
            end
        end
    end

`ifdef VPROC_DIV_RESPACK_ERRCHK_EN
    // Sticky flag: a later beat of a group named a different register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            err <= 1'b0;
        end else if (!sync_rst_ni) begin
            err <= 1'b0;
        end else if (beat_fire && (cnt != '0) && (beat_vd != acc_vd)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/vproc_div_respack.sv
// Packs divider result beats into full vector register writes.
// Optional group-consistency check: define VPROC_DIV_RESPACK_ERRCHK_EN.
module vproc_div_respack
    import vproc_pkg::*;
#(
    parameter int unsigned DIV_OP_W       = 64,
    parameter int unsigned VREG_W         = 128,
    parameter int unsigned VADDR_W        = 5,
    parameter logic        DONT_CARE_ZERO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  sync_rst_ni,
    input  logic                  pipe_in_valid_i,
    output logic                  pipe_in_ready_o,
    input  logic [DIV_OP_W-1:0]   pipe_in_res_i,
    input  logic [DIV_OP_W/8-1:0] pipe_in_mask_i,
    input  logic [VADDR_W-1:0]    pipe_in_vd_i,
    input  logic                  pipe_in_last_i,
    output logic                  vreg_wr_valid_o,
    input  logic                  vreg_wr_ready_i,
    output logic [VADDR_W-1:0]    vreg_wr_addr_o,
    output logic [VREG_W-1:0]     vreg_wr_data_o,
    output logic [VREG_W/8-1:0]   vreg_wr_be_o,
    output logic                  err_o
);

    logic                  in_fire;
    logic                  complete_c;
    logic [VREG_W-1:0]     merged_data_c;
    logic [VREG_W/8-1:0]   merged_be_c;
    logic [VADDR_W-1:0]    merged_vd_c;
    logic                  out_valid;
    div_wr_req_t           out_q;

    // Only a group-closing beat has to wait for the pending write to drain.
    assign pipe_in_ready_o = ~out_valid | vreg_wr_ready_i | ~complete_c;
    assign in_fire         = pipe_in_valid_i & pipe_in_ready_o;

    vproc_div_respack_acc #(
        .DIV_OP_W       (DIV_OP_W),
        .VREG_W         (VREG_W),
        .VADDR_W        (VADDR_W),
        .DONT_CARE_ZERO (DONT_CARE_ZERO)
    ) u_acc (
        .clk_i         (clk_i),
        .async_rst_ni  (async_rst_ni),
        .sync_rst_ni   (sync_rst_ni),
        .beat_fire     (in_fire),
        .beat_res      (pipe_in_res_i),
        .beat_mask     (pipe_in_mask_i),
        .beat_vd       (pipe_in_vd_i),
        .beat_last     (pipe_in_last_i),
        .complete_c    (complete_c),
        .merged_data_c (merged_data_c),
        .merged_be_c   (merged_be_c),
        .merged_vd_c   (merged_vd_c),
        .err           (err_o)
    );

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (!sync_rst_ni) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (in_fire && complete_c) begin
            out_valid  <= 1'b1;
            out_q.addr <= DIV_WR_ADDR_W'(merged_vd_c);
            out_q.data <= DIV_WR_DATA_W'(merged_data_c);
            out_q.be   <= DIV_WR_BE_W'(merged_be_c);
        end else if (vreg_wr_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    assign vreg_wr_valid_o = out_valid;
    assign vreg_wr_addr_o  = VADDR_W'(out_q.addr);
    assign vreg_wr_data_o  = VREG_W'(out_q.data);
    assign vreg_wr_be_o    = (VREG_W/8)'(out_q.be);

endmodule

// File: tb/tb_vproc_div_respack.sv
// Directed table-driven bench for vproc_div_respack (64-bit beats, 128-bit vregs).
module tb_vproc_div_respack;

    typedef struct {
        logic         v;
        logic [63:0]  res;
        logic [7:0]   mask;
        logic [4:0]   vd;
        logic         last;
        logic         rdy;
        logic         srst_n;
        logic         e_in_rdy;
        logic         e_wv;
        logic         cd;
        logic [4:0]   e_addr;
        logic [127:0] e_data;
        logic [15:0]  e_be;
        logic         e_err;
    } vec_t;

`ifdef VPROC_DIV_RESPACK_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    localparam int NV = 23;

    logic         clk_i = 1'b0;
    logic         async_rst_ni;
    logic         sync_rst_ni;
    logic         pipe_in_valid_i;
    logic         pipe_in_ready_o;
    logic [63:0]  pipe_in_res_i;
    logic [7:0]   pipe_in_mask_i;
    logic [4:0]   pipe_in_vd_i;
    logic         pipe_in_last_i;
    logic         vreg_wr_valid_o;
    logic         vreg_wr_ready_i;
    logic [4:0]   vreg_wr_addr_o;
    logic [127:0] vreg_wr_data_o;
    logic [15:0]  vreg_wr_be_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;

    vproc_div_respack #(
        .DIV_OP_W       (64),
        .VREG_W         (128),
        .VADDR_W        (5),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .async_rst_ni    (async_rst_ni),
        .sync_rst_ni     (sync_rst_ni),
        .pipe_in_valid_i (pipe_in_valid_i),
        .pipe_in_ready_o (pipe_in_ready_o),
        .pipe_in_res_i   (pipe_in_res_i),
        .pipe_in_mask_i  (pipe_in_mask_i),
        .pipe_in_vd_i    (pipe_in_vd_i),
        .pipe_in_last_i  (pipe_in_last_i),
        .vreg_wr_valid_o (vreg_wr_valid_o),
        .vreg_wr_ready_i (vreg_wr_ready_i),
        .vreg_wr_addr_o  (vreg_wr_addr_o),
        .vreg_wr_data_o  (vreg_wr_data_o),
        .vreg_wr_be_o    (vreg_wr_be_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [63:0] res, input logic [7:0] mask,
                                input logic [4:0] vd, input logic last, input logic rdy,
                                input logic srst_n, input logic e_in_rdy, input logic e_wv,
                                input logic cd, input logic [4:0] e_addr, input logic [127:0] e_data,
                                input logic [15:0] e_be, input logic e_err);
        vec_t r;
        r.v = v; r.res = res; r.mask = mask; r.vd = vd; r.last = last; r.rdy = rdy;
        r.srst_n = srst_n; r.e_in_rdy = e_in_rdy; r.e_wv = e_wv; r.cd = cd;
        r.e_addr = e_addr; r.e_data = e_data; r.e_be = e_be; r.e_err = e_err;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [63:0] res, input logic [7:0] mask,
                         input logic [4:0] vd, input logic last, input logic rdy, input logic srst_n);
        pipe_in_valid_i = v;
        pipe_in_res_i   = res;
        pipe_in_mask_i  = mask;
        pipe_in_vd_i    = vd;
        pipe_in_last_i  = last;
        vreg_wr_ready_i = rdy;
        sync_rst_ni     = srst_n;
    endtask

    vec_t vt [NV];

    initial begin
        logic [63:0] a, b, c, d, e, f, g, h, i9, j, k;
        logic [63:0] sbeat [8];
        int writes;
        logic exp_wv;

        a  = 64'h1111111111111111; b = 64'h2222222222222222; c = 64'h3333333333333333;
        d  = 64'h4444444444444444; e = 64'h5555555555555555; f = 64'h6666666666666666;
        g  = 64'h7777777777777777; h = 64'h8888888888888888; i9 = 64'h9999999999999999;
        j  = 64'hAAAAAAAAAAAAAAAA; k = 64'hBBBBBBBBBBBBBBBB;

        //           v  res  mask   vd last rdy srst | in_rdy wv cd addr data          be        err
        vt[0]  = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 0, 1, 0, '0,           16'h0000, 0);
        vt[1]  = mk(1, a,  8'hFF, 3, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[2]  = mk(1, b,  8'hFF, 3, 1, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[3]  = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 3, {b, a},       16'hFFFF, 0);
        vt[4]  = mk(1, c,  8'h0F, 7, 1, 0, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[5]  = mk(1, d,  8'hFF, 2, 0, 0, 1,   1, 1, 1, 7, {64'h0, c},   16'h000F, 0);
        vt[6]  = mk(1, e,  8'hFF, 2, 0, 0, 1,   0, 1, 1, 7, {64'h0, c},   16'h000F, 0);
        vt[7]  = mk(1, e,  8'hFF, 2, 0, 1, 1,   1, 1, 1, 7, {64'h0, c},   16'h000F, 0);
        vt[8]  = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 2, {e, d},       16'hFFFF, 0);
        vt[9]  = mk(1, f,  8'hFF, 9, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[10] = mk(0, '0, 8'h00, 0, 0, 1, 0,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[11] = mk(1, g,  8'hFF, 5, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[12] = mk(1, h,  8'hFF, 5, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[13] = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 5, {h, g},       16'hFFFF, 0);
        vt[14] = mk(1, i9, 8'hFF, 3, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[15] = mk(1, j,  8'h0F, 4, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, 0);
        vt[16] = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 3, {j, i9},      16'h0FFF, ERRCHK);
        vt[17] = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, ERRCHK);
        vt[18] = mk(1, '0, 8'h00, 6, 0, 1, 1,   1, 0, 0, 0, '0,           16'h0000, ERRCHK);
        vt[19] = mk(1, k,  8'hFF, 6, 1, 1, 1,   1, 0, 0, 0, '0,           16'h0000, ERRCHK);
        vt[20] = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 1, 1, 6, {k, 64'h0},   16'hFF00, ERRCHK);
        vt[21] = mk(0, '0, 8'h00, 0, 0, 1, 0,   1, 0, 0, 0, '0,           16'h0000, ERRCHK);
        vt[22] = mk(0, '0, 8'h00, 0, 0, 1, 1,   1, 0, 1, 0, '0,           16'h0000, 0);

        // Asynchronous reset state
        async_rst_ni = 1'b0;
        drive(0, '0, '0, '0, 0, 1, 1);
        #12;
        chk("rst_valid", -1, 128'(vreg_wr_valid_o), 128'(0));
        chk("rst_addr",  -1, 128'(vreg_wr_addr_o),  128'(0));
        chk("rst_data",  -1, vreg_wr_data_o,        128'(0));
        chk("rst_be",    -1, 128'(vreg_wr_be_o),    128'(0));
        chk("rst_err",   -1, 128'(err_o),           128'(0));
        async_rst_ni = 1'b1;

        for (int n = 0; n < NV; n++) begin
            @(posedge clk_i); #1;
            drive(vt[n].v, vt[n].res, vt[n].mask, vt[n].vd, vt[n].last, vt[n].rdy, vt[n].srst_n);
            @(negedge clk_i);
            chk("in_ready", n, 128'(pipe_in_ready_o), 128'(vt[n].e_in_rdy));
            chk("wr_valid", n, 128'(vreg_wr_valid_o), 128'(vt[n].e_wv));
            chk("err",      n, 128'(err_o),           128'(vt[n].e_err));
            if (vt[n].cd) begin
                chk("wr_addr", n, 128'(vreg_wr_addr_o), 128'(vt[n].e_addr));
                chk("wr_data", n, vreg_wr_data_o,       vt[n].e_data);
                chk("wr_be",   n, 128'(vreg_wr_be_o),   128'(vt[n].e_be));
            end
        end

        // Streaming: 8 back-to-back beats with the register file always ready
        for (int s = 0; s < 8; s++) sbeat[s] = 64'hC0DE_0000_0000_0000 | 64'(s);
        writes = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk_i); #1;
            if (cyc < 8) drive(1, sbeat[cyc], 8'hFF, 5'(cyc / 2), 0, 1, 1);
            else         drive(0, '0, '0, '0, 0, 1, 1);
            @(negedge clk_i);
            if (cyc < 8) chk("stream_in_ready", cyc, 128'(pipe_in_ready_o), 128'(1));
            exp_wv = (cyc >= 2) && (cyc % 2 == 0);
            chk("stream_wr_valid", cyc, 128'(vreg_wr_valid_o), 128'(exp_wv));
            if (vreg_wr_valid_o) begin
                chk("stream_addr", cyc, 128'(vreg_wr_addr_o), 128'(writes));
                chk("stream_data", cyc, vreg_wr_data_o, {sbeat[2*writes+1], sbeat[2*writes]});
                writes++;
            end
        end
        chk("stream_writes", 99, 128'(writes), 128'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
